// File: rtl/count_mod_pkg.sv
// count_mod shared constants and parameter legality helpers.
// Imported by the counter top and its prescaler.
package count_mod_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic bit modulo_ok(int w, int m);
    longint lim;
    lim = longint'(1) << w;
    return (w >= 1) && (longint'(m) >= 2) && (longint'(m) <= lim);
  endfunction

  function automatic bit div_ok(int d);
    return d >= 1;
  endfunction

  function automatic bit mode_ok(int m);
    return (m == MODE_WRAP) || (m == MODE_SAT);
  endfunction

endpackage

// File: rtl/count_mod_prescale.sv
// Prescaler: divides enabled cycles by DIV, one tick per DIV.
// sync_clr restarts the phase and suppresses the tick.
module count_prescale
  import count_mod_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (!div_ok(DIV)) begin : g_bad_div
    $error("count_prescale: DIV must be >= 1");
  end

  logic [PW-1:0] cnt;

  assign tick = en & ~sync_clr & (cnt == LAST);

  // phase counter, advances only on enabled cycles
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/count_mod.sv
// Modulo up/down counter with prescale, wrap or saturate.
// tc pulses with the new y after each boundary step.
module count_mod
  import count_mod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODULO = 256,
  parameter int DIV    = 1,
  parameter int MODE   = MODE_WRAP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             ovf
);

  if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_mod
    $error("count_mod: MODULO outside 2..2**WIDTH");
  end
  if (!mode_ok(MODE)) begin : g_bad_mode
    $error("count_mod: MODE must be MODE_WRAP or MODE_SAT");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam bit SAT = (MODE == MODE_SAT);

  logic             tick;
  logic             at_top;
  logic             at_bot;
  logic             bnd;
  logic [WIDTH-1:0] y_step;
  logic [WIDTH-1:0] ld_val;

  count_prescale #(
    .DIV(DIV)
  ) u_pre (
    .clk     (clk),
    .res     (res),
    .en      (en),
    .sync_clr(clr | load),
    .tick    (tick)
  );

  // next value of a step and whether it hits a boundary
  always_comb begin
    at_top = (y == MAX);
    at_bot = (y == '0);
    bnd    = tick & (up ? at_top : at_bot);
    ld_val = (load_val > MAX) ? MAX : load_val;
    y_step = y;
    if (up) begin
      if (at_top) y_step = SAT ? MAX : '0;
      else        y_step = y + WIDTH'(1);
    end else begin
      if (at_bot) y_step = SAT ? '0 : MAX;
      else        y_step = y - WIDTH'(1);
    end
  end

  // count register, tc pulse and sticky ovf
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      y   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= bnd;
      if (clr)       y <= '0;
      else if (load) y <= ld_val;
      else if (tick) y <= y_step;
      if (bnd)          ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule
